muldiv_coproc: RTL and testbench

MULDIV_COPROC -- requirements
Module: muldiv_coproc

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_divider.sv | 114 +++++++++++
 rtl/muldiv_coproc.sv | 178 +++++++++++++++++
 tb/tb_muldiv_coproc.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the multiply/divide coprocessor.
//   op_e        : RV32M funct3 operation encodings (MUL..REMU)
//   state_e     : top-level FSM states
//   div_phase_e : iterative divider phases
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      DV_IDLE = 2'd0,
      DV_ITER = 2'd1,
      DV_FIX  = 2'd2
   } div_phase_e;

   // Width of the multiply latency counter (MUL_STAGES <= 4).
   localparam int unsigned MUL_CNT_W = 2;

endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: radix-2 restoring divider on operand magnitudes.
// XLEN iterations after start_i, then one sign-fix cycle in which done_o is
// high and result_o is valid (combinational from the final quotient/remainder).
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : abandon any running division
//   start_i      : load operands (a_i, b_i, signed_i, rem_i) and begin
//   done_o       : high during the sign-fix cycle
//   result_o     : quotient or remainder, sign-corrected
module muldiv_divider
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear_i,
   input  logic            start_i,
   input  logic            signed_i,
   input  logic            rem_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CW = $clog2(XLEN + 1);

   div_phase_e      phase_q, phase_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            rsel_q, rsel_d;
   logic            bzero_q, bzero_d;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      rsel_d  = rsel_q;
      bzero_d = bzero_q;
      shifted = {rem_q, quo_q[XLEN-1]};
      // diff[XLEN] is the borrow: set when shifted < divisor.
      diff    = shifted - {1'b0, dvs_q};
      if (clear_i) begin
         phase_d = DV_IDLE;
         cnt_d   = '0;
      end else if (start_i) begin
         phase_d = DV_ITER;
         cnt_d   = CW'(XLEN);
         rem_d   = '0;
         quo_d   = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
         dvs_d   = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;
         qneg_d  = signed_i && (a_i[XLEN-1] ^ b_i[XLEN-1]);
         rneg_d  = signed_i && a_i[XLEN-1];
         rsel_d  = rem_i;
         bzero_d = (b_i == '0);
      end else begin
         case (phase_q)
            DV_ITER: begin
               rem_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) phase_d = DV_FIX;
            end
            DV_FIX:  phase_d = DV_IDLE;
            default: phase_d = DV_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= DV_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         rsel_q  <= 1'b0;
         bzero_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         rsel_q  <= rsel_d;
         bzero_q <= bzero_d;
      end
   end

   assign done_o = (phase_q == DV_FIX);

   // With a zero divisor the iteration leaves rem = |a| (sign fix restores a),
   // but the quotient must be forced to all-ones regardless of sign.
   always_comb begin
      if (rsel_q)       result_o = rneg_q ? -rem_q : rem_q;
      else if (bzero_q) result_o = '1;
      else              result_o = qneg_q ? -quo_q : quo_q;
   end

endmodule

// File: rtl/muldiv_coproc.sv
// muldiv_coproc: RV32M-style multiply/divide coprocessor.
// Multiply: MUL_STAGES-cycle pipeline. Divide: muldiv_divider, XLEN+1 cycles.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// finish 1 cycle after accept instead of running the divider.
//   clk, rst_n                       : clock, async active-low reset
//   req_valid_i/req_ready_o          : request handshake
//   req_op_i, req_a_i, req_b_i, req_tag_i : funct3 op, operands, tag
//   rsp_valid_o/rsp_ready_i          : response handshake
//   rsp_result_o, rsp_tag_o          : result and echoed tag
//   flush_i                          : abort in-flight op (wins over accept)
//   busy_o                           : op accepted and not yet retired
module muldiv_coproc
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned MUL_STAGES = 2,
   parameter int unsigned TAG_W      = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [2:0]       req_op_i,
   input  logic [XLEN-1:0]  req_a_i,
   input  logic [XLEN-1:0]  req_b_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [XLEN-1:0]  rsp_result_o,
   output logic [TAG_W-1:0] rsp_tag_o,
   input  logic             flush_i,
   output logic             busy_o
);

   state_e                 state_q, state_d;
   op_e                    op_q;
   logic [XLEN-1:0]        a_q, b_q;
   logic [TAG_W-1:0]       tag_q;
   logic [XLEN-1:0]        res_q, res_d;
   logic [MUL_CNT_W-1:0]   mcnt_q, mcnt_d;
   logic                   accept;
   logic                   div_start;
   logic                   div_done;
   logic [XLEN-1:0]        div_result;

   assign accept = req_valid_i && (state_q == IDLE) && !flush_i;

   // Sign-extend to 2*XLEN; the low 2*XLEN product bits are then correct for
   // signed, mixed and unsigned forms alike.
   logic            a_sx, b_sx;
   logic [2*XLEN-1:0] mul_a, mul_b, prod;
   logic [XLEN-1:0] mul_res, mul_out;

   always_comb begin
      a_sx    = (op_q == OP_MULH) || (op_q == OP_MULHSU);
      b_sx    = (op_q == OP_MULH);
      mul_a   = {{XLEN{a_sx && a_q[XLEN-1]}}, a_q};
      mul_b   = {{XLEN{b_sx && b_q[XLEN-1]}}, b_q};
      prod    = mul_a * mul_b;
      mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   // The final pipeline stage is res_q itself, loaded on entry to DONE.
   if (MUL_STAGES == 1) begin : g_nopipe
      assign mul_out = mul_res;
   end else begin : g_pipe
      logic [XLEN-1:0] pipe_q [MUL_STAGES-1];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int unsigned i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= mul_res;
            for (int unsigned i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end
      assign mul_out = pipe_q[MUL_STAGES-2];
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic            special_q, special_d;
   logic [XLEN-1:0] special_res;
   always_comb begin
      special_d = (req_b_i == '0) ||
                  (!req_op_i[0] && (req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (req_b_i == '1));
      if (op_q[1]) special_res = (b_q == '0) ? a_q : '0;
      else         special_res = (b_q == '0) ? '1  : a_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      special_q <= 1'b0;
      else if (accept) special_q <= special_d;
   end
`endif

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      mcnt_d    = mcnt_q;
      div_start = accept && req_op_i[2];
`ifdef MULDIV_EARLY_OUT_EN
      if (special_d) div_start = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = req_op_i[2] ? DIV : MUL;
               mcnt_d  = '0;
            end
         end
         MUL: begin
            if (mcnt_q == MUL_CNT_W'(MUL_STAGES - 1)) begin
               state_d = DONE;
               res_d   = mul_out;
            end else begin
               mcnt_d = mcnt_q + 1'b1;
            end
         end
         DIV: begin
`ifdef MULDIV_EARLY_OUT_EN
            if (special_q) begin
               state_d = DONE;
               res_d   = special_res;
            end else
`endif
            if (div_done) begin
               state_d = DONE;
               res_d   = div_result;
            end
         end
         DONE: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_MUL;
         a_q     <= '0;
         b_q     <= '0;
         tag_q   <= '0;
         res_q   <= '0;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         mcnt_q  <= mcnt_d;
         if (accept) begin
            op_q  <= op_e'(req_op_i);
            a_q   <= req_a_i;
            b_q   <= req_b_i;
            tag_q <= req_tag_i;
         end
      end
   end

   muldiv_divider #(.XLEN(XLEN)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (flush_i),
      .start_i  (div_start),
      .signed_i (!req_op_i[0]),
      .rem_i    (req_op_i[1]),
      .a_i      (req_a_i),
      .b_i      (req_b_i),
      .done_o   (div_done),
      .result_o (div_result)
   );

   assign req_ready_o  = (state_q == IDLE);
   assign busy_o       = (state_q != IDLE);
   assign rsp_valid_o  = (state_q == DONE);
   assign rsp_result_o = res_q;
   assign rsp_tag_o    = tag_q;

endmodule

// File: tb/tb_muldiv_coproc.sv
module tb_muldiv_coproc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_tag;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic [4:0]  rsp_tag;
   logic        flush, busy;

   int total = 0;
   int bad   = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int SPL = 1;
`else
   localparam int SPL = 33;
`endif

   muldiv_coproc #(.XLEN(32), .MUL_STAGES(2), .TAG_W(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_op_i     (req_op),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .req_tag_i    (req_tag),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_result_o (rsp_result),
      .rsp_tag_o    (rsp_tag),
      .flush_i      (flush),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp, input int lat);
      int n;
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op = op ^ 3'd1; req_a = ~a; req_b = ~b; req_tag = ~tag;
      chk({nm, "/busy"}, busy, 1);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "/latency"}, n, lat);
      chk({nm, "/result"}, rsp_result, exp);
      chk({nm, "/tag"}, rsp_tag, tag);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({nm, "/ready_after"}, req_ready, 1);
   endtask

   initial begin
      int n;
      vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 2};
      vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 2};
      vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 2};
      vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 2};
      vecs[4]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 2};
      vecs[5]  = '{3'd3, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 2};
      vecs[6]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFD, 33};
      vecs[7]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFF, 33};
      vecs[8]  = '{3'd5, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'h7FFFFFFC, 33};
      vecs[9]  = '{3'd7, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'h00000001, 33};
      vecs[10] = '{3'd5, 32'h00000005, 32'h00000000, 5'd11, 32'hFFFFFFFF, SPL};
      vecs[11] = '{3'd7, 32'h00000005, 32'h00000000, 5'd12, 32'h00000005, SPL};
      vecs[12] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, SPL};
      vecs[13] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, SPL};
      vecs[14] = '{3'd4, 32'hFFFFFFF9, 32'h00000000, 5'd15, 32'hFFFFFFFF, SPL};
      vecs[15] = '{3'd6, 32'hFFFFFFF9, 32'h00000000, 5'd16, 32'hFFFFFFF9, SPL};
      vecs[16] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 5'd17, 32'hFFFFFFFD, 33};
      vecs[17] = '{3'd6, 32'h00000007, 32'hFFFFFFFE, 5'd18, 32'h00000001, 33};
      vecs[18] = '{3'd5, 32'h00000064, 32'h00000007, 5'd19, 32'h0000000E, 33};
      vecs[19] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, 33};

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0;
      req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset/rsp_valid", rsp_valid, 0);
      chk("reset/req_ready", req_ready, 1);
      chk("reset/busy", busy, 0);
      chk("reset/result", rsp_result, 0);
      chk("reset/tag", rsp_tag, 0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < NV; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].tag, vecs[i].exp, vecs[i].lat);

      // Response back-pressure: outputs hold while rsp_ready is low.
      @(negedge clk);
      req_op = 3'd0; req_a = 32'd3; req_b = 32'd5; req_tag = 5'd9; req_valid = 1'b1;
      @(posedge clk); #1;
      req_a = 32'd100; req_b = 32'd100; req_tag = 5'd22;
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("stall/latency", n, 2);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk($sformatf("stall%0d/valid", c), rsp_valid, 1);
         chk($sformatf("stall%0d/result", c), rsp_result, 32'd15);
         chk($sformatf("stall%0d/tag", c), rsp_tag, 5'd9);
         chk($sformatf("stall%0d/req_ready", c), req_ready, 0);
         chk($sformatf("stall%0d/busy", c), busy, 1);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("stall/released_valid", rsp_valid, 0);
      chk("stall/released_ready", req_ready, 1);

      // Flush at cycle 10 of a divide, with a competing request.
      @(negedge clk);
      req_op = 3'd5; req_a = 32'd100; req_b = 32'd7; req_tag = 5'd1; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 32'd2; req_b = 32'd2;
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      chk("flush/req_ready", req_ready, 1);
      chk("flush/busy", busy, 0);
      chk("flush/rsp_valid", rsp_valid, 0);
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (rsp_valid || busy) n++;
      end
      chk("flush/no_response", n, 0);
      run_op("after_flush_mul", 3'd0, 32'd6, 32'd7, 5'd2, 32'd42, 2);

      // Reset mid-divide abandons the op.
      @(negedge clk);
      req_op = 3'd4; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd30; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset/rsp_valid", rsp_valid, 0);
      chk("midreset/busy", busy, 0);
      chk("midreset/req_ready", req_ready, 1);
      chk("midreset/result", rsp_result, 0);
      chk("midreset/tag", rsp_tag, 0);
      @(negedge clk); rst_n = 1'b1;
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (rsp_valid || busy) n++;
      end
      chk("midreset/no_response", n, 0);
      run_op("after_reset_divu", 3'd5, 32'd1000, 32'd3, 5'd4, 32'd333, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
